md_sequencer: RTL

//  Multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage; owns the HI/LO registers.

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_alu.sv | 22 ++
 rtl/md_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared constants for the multiply/divide sequencer and the EX-stage ALU
package md_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ABS_A  = 3'd1;
    localparam logic [2:0] S_ABS_B  = 3'd2;
    localparam logic [2:0] S_ITER   = 3'd3;
    localparam logic [2:0] S_FIX_LO = 3'd4;
    localparam logic [2:0] S_FIX_HI = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_alu.sv
// rtl/md_alu.sv - EX-stage ALU slice used by the sequencer (add/sub)
module md_alu
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, driving an external ALU
module md_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mdOp,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] aluInA,
    output logic [WIDTH-1:0] aluInB,
    output logic [2:0]       aluOp,
    input  logic [WIDTH-1:0] aluResult,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [2:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_divz;

    logic             w_is_div;
    logic             w_signed;
    logic             w_top;
    logic [WIDTH-1:0] w_sh;
    logic             w_carry;
    logic             w_q_bit;
    logic [2:0]       w_next_state;

    assign w_is_div = r_op[1];
    assign w_signed = md_is_signed(r_op);
    // Divide step works on the 33-bit partial remainder {top, sh}
    assign w_top    = r_hi[WIDTH-1];
    assign w_sh     = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_carry  = (aluResult < r_hi);
    assign w_q_bit  = w_top | (w_sh >= r_b);

    always_comb begin
        aluInA       = '0;
        aluInB       = '0;
        aluOp        = ALU_ADD;
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_ABS_A;
            end
            S_ABS_A: begin
                if (w_signed && r_a[WIDTH-1]) begin
                    aluInB = r_a;
                    aluOp  = ALU_SUB;
                end else begin
                    aluInA = r_a;
                end
                w_next_state = S_ABS_B;
            end
            S_ABS_B: begin
                if (w_signed && r_b[WIDTH-1]) begin
                    aluInB = r_b;
                    aluOp  = ALU_SUB;
                end else begin
                    aluInA = r_b;
                end
                w_next_state = S_ITER;
            end
            S_ITER: begin
                if (w_is_div) begin
                    aluInA = w_sh;
                    aluInB = r_b;
                    aluOp  = ALU_SUB;
                end else begin
                    aluInA = r_hi;
                    aluInB = r_lo[0] ? r_a : '0;
                end
                if (r_cnt == LAST_ITER) w_next_state = S_FIX_LO;
            end
            S_FIX_LO: begin
                if (r_divz) begin
                    aluInA = '1;
                end else if (r_neg_res) begin
                    aluInB = r_lo;
                    aluOp  = ALU_SUB;
                end else begin
                    aluInA = r_lo;
                end
                w_next_state = S_FIX_HI;
            end
            S_FIX_HI: begin
                // Divide-by-zero needs no override here: the remainder already equals srcA
                if (!w_is_div && r_neg_res) begin
                    aluInA = ~r_hi;
                    aluInB = WIDTH'(r_lo == '0);
                end else if (w_is_div && r_neg_rem) begin
                    aluInB = r_hi;
                    aluOp  = ALU_SUB;
                end else begin
                    aluInA = r_hi;
                end
                w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= MD_MULT;
            r_a       <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_divz    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op      <= mdOp;
                        r_a       <= srcA;
                        r_b       <= srcB;
                        r_cnt     <= '0;
                        r_neg_res <= md_is_signed(mdOp) & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        r_neg_rem <= (mdOp == MD_DIV) & srcA[WIDTH-1];
                        r_divz    <= mdOp[1] & (srcB == '0);
                    end else begin
                        if (hiWe) r_hi <= wrData;
                        if (loWe) r_lo <= wrData;
                    end
                end
                S_ABS_A: r_a <= aluResult;
                S_ABS_B: begin
                    r_b  <= aluResult;
                    r_hi <= '0;
                    r_lo <= w_is_div ? r_a : aluResult;
                end
                S_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_is_div) begin
                        r_hi <= w_q_bit ? aluResult : w_sh;
                        r_lo <= {r_lo[WIDTH-2:0], w_q_bit};
                    end else begin
                        r_hi <= {w_carry, aluResult[WIDTH-1:1]};
                        r_lo <= {aluResult[0], r_lo[WIDTH-1:1]};
                    end
                end
                S_FIX_LO: r_lo <= aluResult;
                S_FIX_HI: r_hi <= aluResult;
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
